tier2_tile_sequencer: RTL and testbench

TIER2_TILE_SEQUENCER -- requirements
Module: tier2_tile_sequencer

---
 rtl/tier2_tile_sequencer.sv | 133 +++++++++++++
 tb/tb_tier2_tile_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tier2_tile_sequencer.sv
// Tier-2 tile sequencer: walks each tile through buffer wait, truncation-point calc,
// codestream generation and a datapath flush; a per-state watchdog aborts stuck tiles.
module tier2_tile_sequencer #(
  parameter int RST_SYN_CYCLES = 4,
  parameter int TIMEOUT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [7:0]           tile_total,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  input  logic                 buffer_all_over,
  input  logic                 cal_truncation_point_over,
  input  logic                 codestream_generate_over,
  output logic                 cal_truncation_point_start,
  output logic                 codestream_generate_start,
  output logic                 rst_syn,
  output logic [7:0]           tile_counter,
  output logic                 busy,
  output logic                 image_done,
  output logic                 timeout_error,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_BUF = 3'd1,
    S_CAL      = 3'd2,
    S_GEN      = 3'd3,
    S_FLUSH    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]           FL_LAST = 4'(RST_SYN_CYCLES - 1);

  state_t               cur;
  state_t               nxt;
  logic [7:0]           total_q;
  logic [7:0]           tile_cnt;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic [3:0]           fl_cnt;
  logic                 aborted;
  logic                 err;
  logic                 tmo;
  logic                 tmo_take;
  logic                 fl_last;
  logic                 last_tile;
  logic                 in_wait;

  // wd_cnt holds the cycles already spent in this state, so the limit is hit in cycle #limit
  assign tmo       = (timeout_limit != '0) && (wd_cnt == timeout_limit - WD_ONE);
  assign fl_last   = (fl_cnt == FL_LAST);
  assign last_tile = ((tile_cnt + 8'd1) == total_q);
  assign in_wait   = (cur == S_WAIT_BUF) || (cur == S_CAL) || (cur == S_GEN);

  always_comb begin
    nxt      = cur;
    tmo_take = 1'b0;
    case (cur)
      S_IDLE:     if (enable) nxt = S_WAIT_BUF;
      S_WAIT_BUF: begin
        if (buffer_all_over) nxt = S_CAL;
        else if (tmo) begin
          nxt      = S_FLUSH;
          tmo_take = 1'b1;
        end
      end
      S_CAL: begin
        if (cal_truncation_point_over) nxt = S_GEN;
        else if (tmo) begin
          nxt      = S_FLUSH;
          tmo_take = 1'b1;
        end
      end
      S_GEN: begin
        if (codestream_generate_over) nxt = S_FLUSH;
        else if (tmo) begin
          nxt      = S_FLUSH;
          tmo_take = 1'b1;
        end
      end
      S_FLUSH: begin
        if (fl_last) begin
          if (aborted)        nxt = S_IDLE;
          else if (last_tile) nxt = S_DONE;
          else                nxt = S_WAIT_BUF;
        end
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= S_IDLE;
      total_q  <= 8'd1;
      tile_cnt <= 8'd0;
      wd_cnt   <= '0;
      fl_cnt   <= 4'd0;
      aborted  <= 1'b0;
      err      <= 1'b0;
    end else begin
      cur <= nxt;
      // saturate so a disabled watchdog never wraps back to zero and refires a start pulse
      if (nxt != cur)                    wd_cnt <= '0;
      else if (in_wait && wd_cnt != '1)  wd_cnt <= wd_cnt + WD_ONE;
      fl_cnt <= (cur == S_FLUSH) ? fl_cnt + 4'd1 : 4'd0;
      if (cur == S_IDLE && enable) begin
        total_q  <= (tile_total == 8'd0) ? 8'd1 : tile_total;
        tile_cnt <= 8'd0;
        err      <= 1'b0;
        aborted  <= 1'b0;
      end
      if (tmo_take) begin
        err     <= 1'b1;
        aborted <= 1'b1;
      end
      if (cur == S_FLUSH && fl_last && !aborted) tile_cnt <= tile_cnt + 8'd1;
    end
  end

  assign state                      = cur;
  assign busy                       = (cur != S_IDLE);
  assign cal_truncation_point_start = (cur == S_CAL) && (wd_cnt == '0);
  assign codestream_generate_start  = (cur == S_GEN) && (wd_cnt == '0);
  assign rst_syn                    = (cur == S_FLUSH);
  assign image_done                 = (cur == S_DONE);
  assign tile_counter               = tile_cnt;
  assign timeout_error              = err;

endmodule

// File: tb/tb_tier2_tile_sequencer.sv
// Randomised bench for tier2_tile_sequencer; expected timing comes from per-phase delay
// arithmetic (over in cycle d+1 of a phase, timeout in cycle #limit unless the over is earlier or same).
module tb_tier2_tile_sequencer;
  localparam int RSC = 4;
  localparam int TW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [7:0]    tile_total = 8'd0;
  logic [TW-1:0] timeout_limit = '0;
  logic          buffer_all_over = 1'b0;
  logic          cal_truncation_point_over = 1'b0;
  logic          codestream_generate_over = 1'b0;
  logic          cal_truncation_point_start;
  logic          codestream_generate_start;
  logic          rst_syn;
  logic [7:0]    tile_counter;
  logic          busy;
  logic          image_done;
  logic          timeout_error;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;

  tier2_tile_sequencer #(.RST_SYN_CYCLES(RSC), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .tile_total(tile_total),
    .timeout_limit(timeout_limit), .buffer_all_over(buffer_all_over),
    .cal_truncation_point_over(cal_truncation_point_over),
    .codestream_generate_over(codestream_generate_over),
    .cal_truncation_point_start(cal_truncation_point_start),
    .codestream_generate_start(codestream_generate_start),
    .rst_syn(rst_syn), .tile_counter(tile_counter), .busy(busy),
    .image_done(image_done), .timeout_error(timeout_error), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One processing phase (0=WAIT_BUF, 1=CAL, 2=GEN); the matching over arrives in cycle d+1.
  task automatic run_phase(input int ph, input int d, input int limit, input bit noise,
                           input bit hold, output bit ab);
    int to_at;
    ab    = 1'b0;
    to_at = (limit != 0 && limit <= d) ? limit : 0;
    for (int k = 1; k <= d + 1; k++) begin
      checks++;
      if (state !== 3'(ph + 1)) begin errors++; $display("FAIL phase_state: got %0d expected %0d", state, ph + 1); end
      checks++;
      if (cal_truncation_point_start !== (ph == 1 && k == 1)) begin
        errors++; $display("FAIL cal_start: got %0b expected %0b (phase %0d cycle %0d)", cal_truncation_point_start, (ph == 1 && k == 1), ph, k);
      end
      checks++;
      if (codestream_generate_start !== (ph == 2 && k == 1)) begin
        errors++; $display("FAIL gen_start: got %0b expected %0b (phase %0d cycle %0d)", codestream_generate_start, (ph == 2 && k == 1), ph, k);
      end
      checks++;
      if (rst_syn !== 1'b0 || busy !== 1'b1 || image_done !== 1'b0) begin
        errors++; $display("FAIL phase_flags: got rst_syn=%0b busy=%0b done=%0b expected 0/1/0", rst_syn, busy, image_done);
      end
      if (noise) begin
        buffer_all_over           = (ph != 0) ? 1'($urandom_range(1, 0)) : 1'b0;
        cal_truncation_point_over = (ph != 1) ? 1'($urandom_range(1, 0)) : 1'b0;
        codestream_generate_over  = (ph != 2) ? 1'($urandom_range(1, 0)) : 1'b0;
      end
      if (k == d + 1) begin
        case (ph)
          0:       buffer_all_over = 1'b1;
          1:       cal_truncation_point_over = 1'b1;
          default: codestream_generate_over = 1'b1;
        endcase
      end
      enable = hold ? 1'b1 : 1'($urandom_range(1, 0));
      tick();
      buffer_all_over = 1'b0;
      cal_truncation_point_over = 1'b0;
      codestream_generate_over = 1'b0;
      if (k == to_at) begin
        checks++;
        if (state !== 3'd4 || timeout_error !== 1'b1) begin
          errors++; $display("FAIL timeout_entry: got state=%0d err=%0b expected 4/1", state, timeout_error);
        end
        ab = 1'b1;
        return;
      end
    end
    checks++;
    if (state !== 3'(ph + 2) || timeout_error !== 1'b0) begin
      errors++; $display("FAIL phase_exit: got state=%0d err=%0b expected %0d/0", state, timeout_error, ph + 2);
    end
  endtask

  task automatic run_image(input int total, input int limit, input int dmin, input int dmax,
                           input bit noise, input bit hold);
    int eff;
    int done_cnt;
    bit ab;
    eff = (total == 0) ? 1 : total;
    tile_total    = 8'(total);
    timeout_limit = TW'(limit);
    enable        = 1'b1;
    tick();
    tile_total = 8'($urandom);
    enable     = hold;
    checks++;
    if (state !== 3'd1 || tile_counter !== 8'd0 || timeout_error !== 1'b0) begin
      errors++; $display("FAIL start: got state=%0d cnt=%0d err=%0b expected 1/0/0", state, tile_counter, timeout_error);
    end
    done_cnt = 0;
    ab = 1'b0;
    while (!ab && done_cnt < eff) begin
      for (int ph = 0; ph < 3 && !ab; ph++)
        run_phase(ph, $urandom_range(dmax, dmin), limit, noise, hold, ab);
      enable = hold;
      for (int c = 0; c < RSC; c++) begin
        checks++;
        if (state !== 3'd4 || rst_syn !== 1'b1 || image_done !== 1'b0) begin
          errors++; $display("FAIL flush: got state=%0d rst_syn=%0b done=%0b expected 4/1/0 (cycle %0d)", state, rst_syn, image_done, c);
        end
        tick();
      end
      if (ab) begin
        checks++;
        if (state !== 3'd0 || tile_counter !== 8'(done_cnt) || image_done !== 1'b0 || timeout_error !== 1'b1) begin
          errors++; $display("FAIL abort_end: got state=%0d cnt=%0d done=%0b err=%0b expected 0/%0d/0/1", state, tile_counter, image_done, timeout_error, done_cnt);
        end
      end else begin
        done_cnt++;
        checks++;
        if (tile_counter !== 8'(done_cnt)) begin
          errors++; $display("FAIL tile_count: got %0d expected %0d", tile_counter, done_cnt);
        end
        if (done_cnt == eff) begin
          checks++;
          if (state !== 3'd5 || image_done !== 1'b1) begin
            errors++; $display("FAIL done: got state=%0d done=%0b expected 5/1", state, image_done);
          end
          tick();
          checks++;
          if (state !== 3'd0 || image_done !== 1'b0 || busy !== 1'b0 || timeout_error !== 1'b0 || tile_counter !== 8'(eff)) begin
            errors++; $display("FAIL idle_after: got state=%0d done=%0b busy=%0b err=%0b cnt=%0d expected 0/0/0/0/%0d", state, image_done, busy, timeout_error, tile_counter, eff);
          end
        end else begin
          checks++;
          if (state !== 3'd1) begin errors++; $display("FAIL next_tile: got state=%0d expected 1", state); end
        end
      end
    end
    if (!hold) enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (state !== 3'd0 || busy !== 1'b0 || rst_syn !== 1'b0 || image_done !== 1'b0 || tile_counter !== 8'd0 ||
        timeout_error !== 1'b0 || cal_truncation_point_start !== 1'b0 || codestream_generate_start !== 1'b0) begin
      errors++; $display("FAIL reset: got state=%0d busy=%0b cnt=%0d err=%0b expected all 0", state, busy, tile_counter, timeout_error);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_image(2, 0, 3, 3, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_image(3, 10, 20, 20, 1'b0, 1'b0);
  endtask

  task automatic test_ignore();
    timeout_limit = '0;
    tile_total = 8'd1;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cal_truncation_point_over = 1'b1;
      codestream_generate_over  = 1'b1;
      tick();
      checks++;
      if (state !== 3'd1 || cal_truncation_point_start !== 1'b0 || codestream_generate_start !== 1'b0) begin
        errors++; $display("FAIL ignore_wait: got state=%0d cs=%0b gs=%0b expected 1/0/0", state, cal_truncation_point_start, codestream_generate_start);
      end
    end
    cal_truncation_point_over = 1'b0;
    codestream_generate_over  = 1'b0;
    buffer_all_over = 1'b1;
    tick();
    buffer_all_over = 1'b0;
    checks++;
    if (state !== 3'd2 || cal_truncation_point_start !== 1'b1) begin
      errors++; $display("FAIL ignore_cal_entry: got state=%0d cs=%0b expected 2/1", state, cal_truncation_point_start);
    end
    tick();
    checks++;
    if (state !== 3'd2 || cal_truncation_point_start !== 1'b0 || codestream_generate_start !== 1'b0) begin
      errors++; $display("FAIL ignore_not_remembered: got state=%0d cs=%0b gs=%0b expected 2/0/0", state, cal_truncation_point_start, codestream_generate_start);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_zero_total();
    run_image(0, 0, 0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_reset_in_gen();
    bit ab;
    tile_total = 8'd3;
    timeout_limit = '0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    run_phase(0, 1, 0, 1'b0, 1'b0, ab);
    run_phase(1, 2, 0, 1'b0, 1'b0, ab);
    enable = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (state !== 3'd0 || busy !== 1'b0 || rst_syn !== 1'b0 || image_done !== 1'b0 || tile_counter !== 8'd0 ||
        timeout_error !== 1'b0 || cal_truncation_point_start !== 1'b0 || codestream_generate_start !== 1'b0) begin
      errors++; $display("FAIL reset_in_gen: got state=%0d busy=%0b cnt=%0d err=%0b expected all 0", state, busy, tile_counter, timeout_error);
    end
  endtask

  task automatic test_race();
    run_image(2, 5, 4, 4, 1'b0, 1'b0);
  endtask

  task automatic test_enable_hold();
    run_image(1, 0, 0, 2, 1'b0, 1'b1);
    tick();
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL enable_hold_restart: got state=%0d expected 1", state); end
    enable = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_max_tiles();
    run_image(255, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      run_image($urandom_range(4, 1), ($urandom_range(1, 0) == 1) ? $urandom_range(8, 2) : 0,
                0, 7, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_ignore();
    test_zero_total();
    test_reset_in_gen();
    test_race();
    test_enable_hold();
    test_max_tiles();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
